// File: rtl/riscy_line_adapter.sv
// Cache line-fill/writeback responder.
// Splits each 256-bit line request into a 4-beat 64-bit memory burst.
module riscy_line_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [ADDR_WIDTH-1:0]  line_addr,
    input  logic [LINE_WIDTH-1:0]  line_wdata,
    output logic [LINE_WIDTH-1:0]  line_rdata,
    output logic                   line_resp,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((1 << OFF) - 1);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;

    // State and datapath registers; reset discards any partial burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: writes win over reads when both are requested.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (line_write) begin
                    state_d = WR_BURST;
                end else if (line_read) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (mem_resp && cnt_q == LAST) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch request on accept, collect/advance beats on mem_resp.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (line_write || line_read) begin
                    addr_d  = line_addr & ~OFF_MASK;
                    wdata_d = line_wdata;
                    cnt_d   = '0;
                end
            end
            RD_BURST: begin
                if (mem_resp) begin
                    rdata_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_BURST: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; write beat selected by the counter.
    always_comb begin
        mem_read   = (state_q == RD_BURST);
        mem_write  = (state_q == WR_BURST);
        line_resp  = (state_q == RESP);
        mem_addr   = addr_q;
        line_rdata = rdata_q;
        mem_wdata  = '0;
        if (state_q == WR_BURST) begin
            mem_wdata = wdata_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];
        end
    end

endmodule

// File: tb/tb_riscy_line_adapter.sv
// Directed self-checking bench for riscy_line_adapter.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_riscy_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int passed = 0;
    int total  = 0;

    riscy_line_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .line_read  (line_read),
        .line_write (line_write),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_resp  (line_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line_read = 1'b0;
        line_write = 1'b0;
        line_addr = 32'hFFFF_FFFF;
        line_wdata = '1;
        mem_rdata = 64'h0;
        mem_resp = 1'b1;
        step();
        step();
        total++;
        if (line_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL rst_ctrl got=%b%b%b exp=000",
                     line_resp, mem_read, mem_write);
        else passed++;
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 64'h0)
            $display("FAIL rst_mem got=%h/%h exp=0/0", mem_addr, mem_wdata);
        else passed++;
        total++;
        if (line_rdata !== 256'h0)
            $display("FAIL rst_rdata got=%h exp=0", line_rdata);
        else passed++;
        rst = 1'b0;
        mem_resp = 1'b0;
        step();
        total++;
        if (mem_read !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL idle_resp_ignored got=%b%b exp=00",
                     mem_read, line_resp);
        else passed++;
    endtask

    task automatic test_read();
        logic [63:0] d [4];
        d[0] = 64'h0011_2233_4455_6677;
        d[1] = 64'h8899_AABB_CCDD_EEFF;
        d[2] = 64'h0123_4567_89AB_CDEF;
        d[3] = 64'hFEDC_BA98_7654_3210;
        line_addr = 32'h0000_1234;
        line_read = 1'b1;
        step();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1220)
            $display("FAIL rd_start got=%b/%h exp=1/00001220",
                     mem_read, mem_addr);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_read !== 1'b1 || line_resp !== 1'b0)
                $display("FAIL rd_beat%0d got=%b%b exp=10",
                         k, mem_read, line_resp);
            else passed++;
            mem_resp = 1'b1;
            mem_rdata = d[k];
            step();
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL rd_resp got=%b%b exp=10", line_resp, mem_read);
        else passed++;
        total++;
        if (line_rdata !== {d[3], d[2], d[1], d[0]})
            $display("FAIL rd_data got=%h exp=%h",
                     line_rdata, {d[3], d[2], d[1], d[0]});
        else passed++;
        line_read = 1'b0;
        step();
        total++;
        if (line_resp !== 1'b0 || line_rdata !== {d[3], d[2], d[1], d[0]})
            $display("FAIL rd_after got=%b/%h exp=0/held",
                     line_resp, line_rdata);
        else passed++;
    endtask

    task automatic test_write();
        logic [255:0] w;
        w = 256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7;
        line_addr = 32'h4000_007F;
        line_wdata = w;
        line_write = 1'b1;
        step();
        line_wdata = ~w;
        line_addr = 32'h1111_1111;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_write !== 1'b1 || mem_wdata !== w[k*64 +: 64])
                $display("FAIL wr_beat%0d got=%b/%h exp=1/%h",
                         k, mem_write, mem_wdata, w[k*64 +: 64]);
            else passed++;
            total++;
            if (mem_addr !== 32'h4000_0060)
                $display("FAIL wr_addr%0d got=%h exp=40000060", k, mem_addr);
            else passed++;
            mem_resp = 1'b1;
            step();
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || mem_write !== 1'b0 || mem_wdata !== 64'h0)
            $display("FAIL wr_resp got=%b%b/%h exp=10/0",
                     line_resp, mem_write, mem_wdata);
        else passed++;
        line_write = 1'b0;
        step();
        total++;
        if (line_resp !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL wr_after got=%b%b exp=00", line_resp, mem_write);
        else passed++;
    endtask

    task automatic test_gaps();
        logic [63:0] d [4];
        logic        pat [7];
        int          b;
        d[0] = 64'h1111_0000_0000_0001;
        d[1] = 64'h2222_0000_0000_0002;
        d[2] = 64'h3333_0000_0000_0003;
        d[3] = 64'h4444_0000_0000_0004;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        b = 0;
        line_addr = 32'h8000_0040;
        line_read = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            total++;
            if (mem_read !== 1'b1 || line_resp !== 1'b0)
                $display("FAIL gap_cyc%0d got=%b%b exp=10",
                         i, mem_read, line_resp);
            else passed++;
            mem_resp = pat[i];
            mem_rdata = pat[i] ? d[b] : 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            if (pat[i]) b++;
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || line_rdata !== {d[3], d[2], d[1], d[0]})
            $display("FAIL gap_resp got=%b/%h exp=1/%h",
                     line_resp, line_rdata, {d[3], d[2], d[1], d[0]});
        else passed++;
        line_read = 1'b0;
        step();
        total++;
        if (line_resp !== 1'b0)
            $display("FAIL gap_single got=%b exp=0", line_resp);
        else passed++;
    endtask

    task automatic test_simul();
        logic [255:0] w;
        logic [63:0]  d [4];
        w = {64'h4, 64'h3, 64'h2, 64'h1};
        d[0] = 64'hAAAA_0000;
        d[1] = 64'hBBBB_0000;
        d[2] = 64'hCCCC_0000;
        d[3] = 64'hDDDD_0000;
        line_addr = 32'h0000_0100;
        line_wdata = w;
        line_read = 1'b1;
        line_write = 1'b1;
        step();
        total++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL both_wrfirst got=%b%b exp=10", mem_write, mem_read);
        else passed++;
        mem_resp = 1'b1;
        repeat (4) step();
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1)
            $display("FAIL both_wresp got=%b exp=1", line_resp);
        else passed++;
        line_write = 1'b0;
        step();
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL both_idle got=%b%b%b exp=000",
                     mem_read, mem_write, line_resp);
        else passed++;
        step();
        total++;
        if (mem_read !== 1'b1)
            $display("FAIL both_rd got=%b exp=1", mem_read);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            mem_resp = 1'b1;
            mem_rdata = d[k];
            step();
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || line_rdata !== {d[3], d[2], d[1], d[0]})
            $display("FAIL both_rdata got=%b/%h exp=1/%h",
                     line_resp, line_rdata, {d[3], d[2], d[1], d[0]});
        else passed++;
        line_read = 1'b0;
        step();
    endtask

    task automatic test_rst_mid();
        logic [63:0] d [4];
        d[0] = 64'h5;
        d[1] = 64'h6;
        d[2] = 64'h7;
        d[3] = 64'h8;
        line_addr = 32'h0000_2000;
        line_read = 1'b1;
        step();
        mem_resp = 1'b1;
        mem_rdata = 64'hEEEE_EEEE;
        step();
        step();
        mem_resp = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (mem_read !== 1'b0 || line_resp !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL rstmid_ctrl got=%b%b/%h exp=00/0",
                     mem_read, line_resp, mem_addr);
        else passed++;
        total++;
        if (line_rdata !== 256'h0)
            $display("FAIL rstmid_rdata got=%h exp=0", line_rdata);
        else passed++;
        step();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_2000)
            $display("FAIL rstmid_restart got=%b/%h exp=1/00002000",
                     mem_read, mem_addr);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            mem_resp = 1'b1;
            mem_rdata = d[k];
            step();
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || line_rdata !== {d[3], d[2], d[1], d[0]})
            $display("FAIL rstmid_done got=%b/%h exp=1/%h",
                     line_resp, line_rdata, {d[3], d[2], d[1], d[0]});
        else passed++;
        line_read = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [255:0] a;
        logic [63:0]  db [4];
        a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        db[0] = 64'hB0;
        db[1] = 64'hB1;
        db[2] = 64'hB2;
        db[3] = 64'hB3;
        line_addr = 32'h0000_3000;
        line_read = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            mem_resp = 1'b1;
            mem_rdata = a[k*64 +: 64];
            step();
        end
        mem_resp = 1'b0;
        total++;
        if (line_resp !== 1'b1 || line_rdata !== a)
            $display("FAIL b2b_a got=%b/%h exp=1/%h", line_resp, line_rdata, a);
        else passed++;
        line_addr = 32'h0000_4020;
        step();
        total++;
        if (mem_addr !== 32'h0000_3000 || line_rdata !== a || mem_read !== 1'b0)
            $display("FAIL b2b_idle got=%h/%b exp=00003000/0",
                     mem_addr, mem_read);
        else passed++;
        step();
        total++;
        if (mem_addr !== 32'h0000_4020 || line_rdata !== a || mem_read !== 1'b1)
            $display("FAIL b2b_accept got=%h/%b exp=00004020/1",
                     mem_addr, mem_read);
        else passed++;
        mem_resp = 1'b1;
        mem_rdata = db[0];
        step();
        total++;
        if (line_rdata !== {a[255:64], db[0]})
            $display("FAIL b2b_beat0 got=%h exp=%h",
                     line_rdata, {a[255:64], db[0]});
        else passed++;
        for (int k = 1; k < 4; k++) begin
            mem_rdata = db[k];
            step();
        end
        mem_resp = 1'b0;
        line_read = 1'b0;
        total++;
        if (line_resp !== 1'b1 || line_rdata !== {db[3], db[2], db[1], db[0]})
            $display("FAIL b2b_b got=%b/%h exp=1/%h", line_resp, line_rdata,
                     {db[3], db[2], db[1], db[0]});
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_gaps();
        test_simul();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
